// File: rtl/radix4_mul_unit.sv
// Radix-4 sequential multiplier: two multiplier bits per cycle, with a
// chunked valid/ready readout of the full-width product.
module radix4_mul_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8,
    localparam int DW = 2 * WIDTH,
    localparam int NCHUNK = DW / CHUNK,
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [DW-1:0]    oProduct,
    output logic             oChunkValid,
    input  logic             iChunkReady,
    output logic [CHUNK-1:0] oChunk,
    output logic [IW-1:0]    oChunkIndex,
    output logic             oChunkLast
);

    localparam int HALF = WIDTH / 2;
    localparam int CW = $clog2(HALF + 1);
    localparam logic [CW-1:0] CNT_END = CW'(HALF);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [DW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic [DW-1:0]    r_product;
    logic             r_done;
    logic [IW-1:0]    r_idx;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_sign;
    logic [DW-1:0]    w_pp;
    logic [DW-1:0]    w_acc_neg;
    logic             w_mul_end;
    logic             w_last;
    logic             w_xfer;
    logic [CHUNK-1:0] w_chunks [NCHUNK];

    // Magnitudes in WIDTH bits: -2^(WIDTH-1) negates to 2^(WIDTH-1) unsigned.
    assign w_mag_a = (iSigned && iA[WIDTH-1]) ? (~iA + WIDTH'(1)) : iA;
    assign w_mag_b = (iSigned && iB[WIDTH-1]) ? (~iB + WIDTH'(1)) : iB;
    assign w_sign  = iSigned && (iA[WIDTH-1] ^ iB[WIDTH-1]);

    always_comb begin
        w_pp = '0;
        unique case (r_mplier[1:0])
            2'd0: w_pp = '0;
            2'd1: w_pp = r_mcand;
            2'd2: w_pp = r_mcand << 1;
            2'd3: w_pp = (r_mcand << 1) + r_mcand;
            default: w_pp = '0;
        endcase
    end

    assign w_acc_neg = ~r_acc + DW'(1);
    assign w_mul_end = (r_cnt == CNT_END);
    assign w_last    = (r_idx == LAST_IDX);
    assign w_xfer    = (r_state == S_DRAIN) && iChunkReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (iStart) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_end) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_xfer && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_product <= '0;
            r_done    <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_sign   <= w_sign;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_MUL: begin
                    // One extra edge after the last digit publishes the result.
                    if (w_mul_end) begin
                        r_product <= r_sign ? w_acc_neg : r_acc;
                        r_done    <= 1'b1;
                        r_idx     <= '0;
                    end else begin
                        r_acc    <= r_acc + w_pp;
                        r_mcand  <= r_mcand << 2;
                        r_mplier <= r_mplier >> 2;
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (iChunkReady) begin
                        r_idx <= w_last ? '0 : r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        assign w_chunks[g] = r_product[g*CHUNK +: CHUNK];
    end

    assign oBusy       = (r_state != S_IDLE);
    assign oDone       = r_done;
    assign oProduct    = r_product;
    assign oChunkValid = (r_state == S_DRAIN);
    assign oChunkIndex = r_idx;
    assign oChunk      = oChunkValid ? w_chunks[r_idx] : '0;
    assign oChunkLast  = oChunkValid && w_last;

endmodule

// File: tb/tb_radix4_mul_unit.sv
// Scoreboard bench for radix4_mul_unit: directed products, chunk stream,
// back-pressure, ignored starts and mid-operation reset.
module tb_radix4_mul_unit;

    logic        clk;
    logic        rst_n;
    logic        iStart;
    logic        iSigned;
    logic [15:0] iA;
    logic [15:0] iB;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oProduct;
    logic        oChunkValid;
    logic        iChunkReady;
    logic [7:0]  oChunk;
    logic [1:0]  oChunkIndex;
    logic        oChunkLast;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
    } chunk_t;

    logic [31:0] pq[$];
    chunk_t      cq[$];
    int          n_checks;
    int          n_fail;
    logic        prev_done;

    radix4_mul_unit #(.WIDTH(16), .CHUNK(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .iStart(iStart),
        .iSigned(iSigned),
        .iA(iA),
        .iB(iB),
        .oBusy(oBusy),
        .oDone(oDone),
        .oProduct(oProduct),
        .oChunkValid(oChunkValid),
        .iChunkReady(iChunkReady),
        .oChunk(oChunk),
        .oChunkIndex(oChunkIndex),
        .oChunkLast(oChunkLast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_expect(input logic [31:0] p);
        chunk_t c;
        pq.push_back(p);
        for (int i = 0; i < 4; i++) begin
            c.idx  = 2'(i);
            c.data = p[i*8 +: 8];
            c.last = (i == 3);
            cq.push_back(c);
        end
    endtask

    // Called at posedge+1 in IDLE; returns at start-edge+1.
    task automatic start_op(input logic s, input logic [15:0] a,
                            input logic [15:0] b, input logic [31:0] p,
                            input bit track);
        if (track) push_expect(p);
        iSigned = s;
        iA      = a;
        iB      = b;
        iStart  = 1'b1;
        @(posedge clk);
        #1;
        iStart  = 1'b0;
        iA      = 16'hDEAD;
        iB      = 16'hBEEF;
        iSigned = ~s;
        check("busy_after_start", oBusy, 1'b1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!oDone && n < 40);
        if (!oDone) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no oDone expected oDone");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (oBusy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_reached", oBusy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, oBusy, 1'b0);
        check({tag, "_done"}, oDone, 1'b0);
        check({tag, "_cvalid"}, oChunkValid, 1'b0);
        check({tag, "_clast"}, oChunkLast, 1'b0);
        check({tag, "_product"}, oProduct, 32'h0);
        check({tag, "_chunk"}, oChunk, 8'h0);
        check({tag, "_cidx"}, oChunkIndex, 2'd0);
    endtask

    // Monitor: pops the scoreboard on oDone and on every chunk transfer.
    initial begin
        logic [31:0] ep;
        chunk_t ec;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (oDone) begin
                check("done_one_cycle", prev_done, 1'b0);
                if (pq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL product_unexpected: got 0x%0h expected none",
                             oProduct);
                end else begin
                    ep = pq.pop_front();
                    check("product", oProduct, ep);
                end
            end
            if (oChunkValid && iChunkReady) begin
                if (cq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL chunk_unexpected: got 0x%0h expected none",
                             oChunk);
                end else begin
                    ec = cq.pop_front();
                    check("chunk_idx", oChunkIndex, ec.idx);
                    check("chunk_data", oChunk, ec.data);
                    check("chunk_last", oChunkLast, ec.last);
                end
            end
            prev_done = oDone;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        iStart      = 1'b0;
        iSigned     = 1'b0;
        iA          = '0;
        iB          = '0;
        iChunkReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start_op(1'b0, 16'h1234, 16'h5678, 32'h06260060, 1'b1);
        wait_done(n);
        check("latency", n, 9);
        wait_idle();

        start_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
        wait_done(n);
        wait_idle();
        start_op(1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 1'b1);
        wait_done(n);
        wait_idle();
        start_op(1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1);
        wait_done(n);
        wait_idle();

        // Back-pressure with index 1 presented
        start_op(1'b0, 16'h1234, 16'h5678, 32'h06260060, 1'b1);
        wait_done(n);
        @(posedge clk);
        #1;
        iChunkReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_idx", oChunkIndex, 2'd1);
            check("stall_chunk", oChunk, 8'h00);
            check("stall_last", oChunkLast, 1'b0);
            @(posedge clk);
            #1;
        end
        check("stall_idx_end", oChunkIndex, 2'd1);
        iChunkReady = 1'b1;
        wait_idle();

        // Starts during MUL, DRAIN and on the last-chunk edge are ignored
        start_op(1'b0, 16'h0003, 16'h0005, 32'h0000000F, 1'b1);
        @(posedge clk);
        #1;
        iStart = 1'b1;
        iA     = 16'h0100;
        iB     = 16'h0100;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        wait_done(n);
        check("latency_mul_start", n, 7);
        iChunkReady = 1'b0;
        iStart      = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        check("drain_start_busy", oBusy, 1'b1);
        check("drain_start_idx", oChunkIndex, 2'd0);
        check("drain_start_prod", oProduct, 32'h0000000F);
        iChunkReady = 1'b1;
        n = 0;
        while (!oChunkLast && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("last_seen", oChunkLast, 1'b1);
        iSigned = 1'b0;
        iA      = 16'h0007;
        iB      = 16'h0009;
        iStart  = 1'b1;
        push_expect(32'h0000003F);
        @(posedge clk);
        #1;
        check("last_edge_busy", oBusy, 1'b0);
        check("last_edge_cvalid", oChunkValid, 1'b0);
        check("last_edge_prod", oProduct, 32'h0000000F);
        @(posedge clk);
        #1;
        iStart = 1'b0;
        iA     = 16'hAAAA;
        check("next_start_busy", oBusy, 1'b1);
        wait_done(n);
        check("latency_restart", n, 9);
        wait_idle();

        // Reset during the fourth iteration
        start_op(1'b0, 16'h1234, 16'h5678, 32'h0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", oBusy, 1'b0);
        start_op(1'b0, 16'h0003, 16'h0005, 32'h0000000F, 1'b1);
        wait_done(n);
        check("latency_post_reset", n, 9);
        wait_idle();

        repeat (2) @(posedge clk);
        #1;
        check("sb_products_left", 64'(pq.size()), 0);
        check("sb_chunks_left", 64'(cq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/radix4_mul_unit.md
RADIX4_MUL_UNIT -- requirements
Module: radix4_mul_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand width; even, >= 4.
REQ-002 Parameter CHUNK, default 8, result chunk width; SHALL divide 2*WIDTH exactly.
REQ-003 Derived NCHUNK = 2*WIDTH/CHUNK; IW = max(1, clog2(NCHUNK)).
REQ-004 Clock  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  reset, asynchronous, active-low.
REQ-006 iStart  input  1  request a multiply; sampled only in IDLE.
REQ-007 iSigned  input  1  1 = two's-complement operands, 0 = unsigned; sampled with iStart.
REQ-008 iA  input  WIDTH  multiplicand; iB  input  WIDTH  multiplier; both sampled with iStart.
REQ-009 oBusy  output  1  high in MUL and DRAIN.
REQ-010 oDone  output  1  one-cycle pulse when the product becomes valid.
REQ-011 oProduct  output  2*WIDTH  full product, held until the next accepted start.
REQ-012 oChunkValid  output  1 / iChunkReady  input  1  chunk stream handshake.
REQ-013 oChunk  output  CHUNK / oChunkIndex  output  IW / oChunkLast  output  1  current chunk, its index, and a last-chunk flag.

Function
REQ-014 FSM states IDLE, MUL, DRAIN; IDLE->MUL on iStart=1; MUL->DRAIN after WIDTH/2 iterations; DRAIN->IDLE on the handshake of the last chunk.
REQ-015 Start acceptance: rising edge in IDLE with iStart=1; operands latched; iStart ignored in MUL and DRAIN.
REQ-016 Signed mode: latch |iA| and |iB| as WIDTH-bit unsigned values and the sign = MSB(iA) XOR MSB(iB).
REQ-016a |-2^(WIDTH-1)| SHALL equal 2^(WIDTH-1), with no overflow.
REQ-017 Each MUL cycle SHALL consume the 2 LSBs of the multiplier magnitude as a radix-4 digit d in 0..3.
REQ-017a The accumulator SHALL add d*multiplicand (0, M, 2M, 2M+M), shifted by 2*k for iteration k.
REQ-018 Accumulator width is 2*WIDTH; no intermediate truncation.
REQ-018a The final unsigned product equals the exact value modulo 2^(2*WIDTH), and always fits.
REQ-019 Signed mode with sign=1: oProduct SHALL be the two's complement of the magnitude product.
REQ-019a -2^(WIDTH-1) * -2^(WIDTH-1) SHALL give 2^(2*WIDTH-2).
REQ-020 Latency: oDone and the valid oProduct SHALL appear in the cycle after the (WIDTH/2)-th MUL edge, i.e. WIDTH/2+1 edges after the start edge.
REQ-020a oDone SHALL remain high for exactly one cycle.
REQ-021 On entry to DRAIN: oChunkValid=1, oChunkIndex=0, oChunk=oProduct[CHUNK-1:0].
REQ-021a Chunks SHALL be emitted LSB first.
REQ-022 A chunk transfer SHALL occur on an edge with oChunkValid & iChunkReady.
REQ-022a After a transfer, the index SHALL increment and oChunk SHALL select the next CHUNK slice.
REQ-022b While iChunkReady=0, oChunk, oChunkIndex and oChunkLast SHALL remain stable.
REQ-023 oChunkLast SHALL be 1 exactly when oChunkIndex = NCHUNK-1.
REQ-023a The transfer with oChunkLast=1 SHALL return the FSM to IDLE and clear oChunkValid.
REQ-024 iStart=1 on the same edge as the last-chunk transfer SHALL be ignored.
REQ-024a A start SHALL be accepted at the earliest on the following edge, in IDLE.
REQ-025 oBusy SHALL be 1 from the edge after start acceptance until the last-chunk transfer edge.
REQ-026 Operand changes on iA, iB and iSigned while busy SHALL have no effect on the result.

Reset
REQ-027 Reset=0 SHALL force, asynchronously: FSM=IDLE; oBusy=0, oDone=0, oChunkValid=0, oChunkLast=0; oProduct=0, oChunk=0, oChunkIndex=0; accumulator and counters=0.
REQ-028 Reset=0 during MUL or DRAIN SHALL abort the operation with no residual state.
REQ-028a After release, the first start SHALL produce a correct result.
REQ-029 Reset release is synchronized externally; the block SHALL leave IDLE no earlier than the first rising edge after release.

Verification (WIDTH=16, CHUNK=8)
REQ-030 Unsigned 0x1234*0x5678 -> oDone 9 edges after start, oProduct=0x06260060; chunks 0x60,0x00,0x26,0x06 with index 0..3; oChunkLast only on index 3.
REQ-031 Unsigned 0xFFFF*0xFFFF -> 0xFFFE0001; signed 0xFFFF*0x0002 -> 0xFFFFFFFE; signed 0x8000*0x8000 -> 0x40000000.
REQ-032 iChunkReady low for 3 cycles after index 1 is presented -> index 1 and oChunk=0x00 stable for all 3 cycles; then the remaining chunks follow in order, no loss or duplication.
REQ-033 iStart pulsed in MUL, in DRAIN, and on the last-chunk edge -> all ignored; a new start one cycle later is accepted; oProduct is unchanged until then.
REQ-034 Reset=0 asserted at iteration 4 of 0x1234*0x5678 -> all outputs 0 immediately; after release, 0x0003*0x0005 -> oProduct=0x0000000F.
